// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: shared state encodings, field_en bit indices and helpers
// for the clock-calendar mode/edit controller.
//   state_t       3-bit FSM state, RUN=0, SET_SEC=1 ... SET_YEAR=6
//   F_*           field_en bit positions {year, month, day, hour, min, sec}
//   FE_ALL        all counters enabled (RUN)
//   next_state()  MODE-press successor, SET_YEAR wraps to RUN
//   field_of()    field_en pattern for a state
package clock_set_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_SEC  = 3'd1,
        SET_MIN  = 3'd2,
        SET_HOUR = 3'd3,
        SET_DAY  = 3'd4,
        SET_MON  = 3'd5,
        SET_YEAR = 3'd6
    } state_t;

    localparam int unsigned F_SEC  = 0;
    localparam int unsigned F_MIN  = 1;
    localparam int unsigned F_HOUR = 2;
    localparam int unsigned F_DAY  = 3;
    localparam int unsigned F_MON  = 4;
    localparam int unsigned F_YEAR = 5;

    localparam logic [5:0] FE_ALL = 6'b111111;

    function automatic state_t next_state(input state_t s);
        return (s == SET_YEAR) ? RUN : state_t'(3'(s) + 3'd1);
    endfunction

    // SET_x states are numbered so that state-1 is the field's bit index.
    function automatic logic [5:0] field_of(input state_t s);
        return (s == RUN) ? FE_ALL : 6'd1 << (3'(s) - 3'd1);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_button_cond.sv
// button_cond: synchronizes, debounces and edge-detects one active-low button.
//   clk, rst   system clock, synchronous active-high reset
//   btn_n_i    raw active-low button, asynchronous to clk
//   press_o    one-cycle pulse on the debounced high->low transition
//   level_o    debounced level (1 = released)
module button_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o,
    output logic level_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample;
    // any agreeing sample restarts the count.
    always_comb begin
        flip    = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        level_d = flip ? sync_q[1] : level_q;
        cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Press is taken at the flip itself so the controller registers it on the
    // same edge the debounced level changes.
    assign press_o = flip & ~sync_q[1];
    assign level_o = level_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET mode controller routing debounced UP/DOWN presses to
// the field being edited of the clock-calendar.
//   clk, rst                      system clock, synchronous active-high reset
//   btn_mode_n/btn_up_n/btn_down_n raw active-low buttons (asynchronous)
//   pulse_1s                      one-cycle time-base tick
//   pulse_1s_out                  tick to the seconds counter, RUN only
//   field_en[5:0]                 counter enables {year,month,day,hour,min,sec}
//   inc_pulse / dec_pulse         one-cycle edit requests for the enabled field
//   blink                         display-on qualifier for the edited field
//   edit_mode                     high in any SET state
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned TIMEOUT_S       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       pulse_1s,
    output logic       pulse_1s_out,
    output logic [5:0] field_en,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink,
    output logic       edit_mode
);

    logic [2:0] raw_n, p, lvl;
    logic       unused_lvl;

    assign raw_n = {btn_mode_n, btn_up_n, btn_down_n};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_n_i(raw_n[i]),
            .press_o(p[i]),
            .level_o(lvl[i])
        );
    end

    assign unused_lvl = &lvl;

    state_t     state_q, state_d;
    logic [5:0] to_q, to_d, field_en_q;
    logic       inc_q, inc_d, dec_q, dec_d, blink_q, blink_d, edit_q;
    logic       in_set, any_p, hit, entry;

    always_comb begin
        in_set  = state_q != RUN;
        any_p   = |p;
        // A press in the same cycle as the final tick cancels the timeout.
        hit     = in_set && TIMEOUT_S != 0 && pulse_1s && !any_p
                  && (to_q + 6'd1 == 6'(TIMEOUT_S));
        state_d = p[2] ? next_state(state_q) : hit ? RUN : state_q;
        entry   = state_d != state_q;
        to_d    = (state_d == RUN || entry || any_p) ? 6'd0
                  : pulse_1s ? to_q + 6'd1 : to_q;
        inc_d   = in_set && p[1] && !p[0] && !p[2];
        dec_d   = in_set && p[0] && !p[1] && !p[2];
        blink_d = (state_d == RUN || entry || (in_set && (p[1] || p[0]))) ? 1'b1
                  : pulse_1s ? ~blink_q : blink_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            to_q       <= 6'd0;
            field_en_q <= FE_ALL;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            blink_q    <= 1'b1;
            edit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_q       <= to_d;
            field_en_q <= field_of(state_d);
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            blink_q    <= blink_d;
            edit_q     <= state_d != RUN;
        end
    end

    assign pulse_1s_out = pulse_1s & (state_q == RUN);
    assign field_en     = field_en_q;
    assign inc_pulse    = inc_q;
    assign dec_pulse    = dec_q;
    assign blink        = blink_q;
    assign edit_mode    = edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p1s = 1'b0;
    logic [2:0] b_n = 3'b111;
    logic       pulse_1s_out, inc_pulse, dec_pulse, blink, edit_mode;
    logic [5:0] field_en;

    clock_set_ctrl #(.DEBOUNCE_CYCLES(20), .TIMEOUT_S(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_mode_n  (b_n[2]),
        .btn_up_n    (b_n[1]),
        .btn_down_n  (b_n[0]),
        .pulse_1s    (p1s),
        .pulse_1s_out(pulse_1s_out),
        .field_en    (field_en),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .blink       (blink),
        .edit_mode   (edit_mode)
    );

    always #5 clk = ~clk;

    int vecs = 0, miss = 0, inc_n = 0, dec_n = 0, fe_bad = 0;
    bit mon = 1'b0;
    int ib, db;
    logic [5:0] fe_exp [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3f};

    always @(negedge clk) begin
        if (inc_pulse) inc_n++;
        if (dec_pulse) dec_n++;
        if (mon && field_en != 6'b000100) fe_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] m);
        b_n = ~m;
        step(25);
        b_n = 3'b111;
        step(25);
    endtask

    task automatic bounce(input logic [2:0] m);
        repeat (2) begin
            b_n = ~m;
            step(5);
            b_n = 3'b111;
            step(5);
        end
        press(m);
    endtask

    task automatic tick();
        p1s = 1'b1;
        step(1);
        p1s = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_edit", edit_mode, 0);
        chk("rst_fe", field_en, 6'h3f);
        chk("rst_blink", blink, 1);
        chk("rst_pulses", {inc_pulse, dec_pulse}, 0);
        p1s = 1'b1;
        #1 chk("run_p1s", pulse_1s_out, 1);
        p1s = 1'b0;
        step(1);
        b_n[2] = 1'b0;
        step(21);
        chk("lat_pre", edit_mode, 0);
        step(1);
        chk("lat_edit", edit_mode, 1);
        chk("lat_fe", field_en, 6'h01);
        p1s = 1'b1;
        #1 chk("set_p1s", pulse_1s_out, 0);
        p1s = 1'b0;
        step(17);
        b_n[2] = 1'b1;
        step(25);
        chk("hold_once", field_en, 6'h01);
        press(3'b100);
        press(3'b100);
        chk("hour_fe", field_en, 6'h04);
        ib = inc_n;
        db = dec_n;
        mon = 1'b1;
        repeat (3) bounce(3'b010);
        bounce(3'b001);
        mon = 1'b0;
        chk("hour_inc", inc_n - ib, 3);
        chk("hour_dec", dec_n - db, 1);
        chk("hour_fe_hold", fe_bad, 0);
        press(3'b100);
        chk("day_fe", field_en, 6'h08);
        ib = inc_n;
        press(3'b110);
        chk("mode_up_fe", field_en, 6'h10);
        chk("mode_up_inc", inc_n - ib, 0);
        ib = inc_n;
        db = dec_n;
        press(3'b011);
        chk("up_dn_fe", field_en, 6'h10);
        chk("up_dn_pulses", (inc_n - ib) + (dec_n - db), 0);
        press(3'b100);
        chk("year_fe", field_en, 6'h20);
        ib = inc_n;
        b_n = 3'b101;
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_edit", edit_mode, 0);
        chk("rst_mid_blink", blink, 1);
        chk("rst_mid_fe", field_en, 6'h3f);
        step(40);
        b_n = 3'b111;
        step(25);
        press(3'b010);
        chk("rst_up_inc", inc_n - ib, 0);
        for (int i = 0; i < 7; i++) begin
            press(3'b100);
            chk($sformatf("seq%0d_fe", i), field_en, fe_exp[i]);
            chk($sformatf("seq%0d_edit", i), edit_mode, i < 6);
        end
        ib = inc_n;
        press(3'b010);
        chk("run_up_inc", inc_n - ib, 0);
        press(3'b100);
        press(3'b100);
        chk("min_fe", field_en, 6'h02);
        chk("min_blink", blink, 1);
        tick();
        chk("tick_blink", blink, 0);
        tick();
        ib = inc_n;
        press(3'b010);
        chk("to_inc", inc_n - ib, 1);
        chk("to_blink", blink, 1);
        tick();
        tick();
        chk("to_hold", edit_mode, 1);
        tick();
        chk("to_run", edit_mode, 0);
        chk("to_fe", field_en, 6'h3f);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
